ps2_kbd_rx: RTL and testbench

PS/2 keyboard receive front end that feeds the keyboard-to-SPART driver. It synchronises and filters the raw ps2_clk and ps2_data pins and deframes 11-bit device-to-host frames. It presents each valid scan-code byte on kbd_databus with a level kbd_rda flag, which stays set until the driver acknowledges it with a one-cycle clear_kbd pulse. Frame errors and overruns are flagged; no host-to-device transmission.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_kbd_rx.sv | 163 ++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared state encoding, frame constants and parity helper for the PS/2
// keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int         FRAME_DATA_BITS = 8;
  localparam logic [7:0] SC_BREAK        = 8'hF0;
  localparam logic [7:0] SC_EXTEND       = 8'hE0;

  // PS/2 frames use odd parity: data bits plus parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 pins, glitch-filters the clock line and flags
// each filtered falling edge together with the synchronised data bit.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_evt,
  output logic data_s
);

  logic [1:0]            r_clk_sync;
  logic [1:0]            r_data_sync;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_clk_filt;
  logic                  w_all_low;
  logic                  w_all_high;

  assign w_all_low  = (r_filt == '0);
  assign w_all_high = (r_filt == '1);

  // Sync flops and filter preset to the idle-high bus level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_filt      <= '1;
      r_clk_filt  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_filt      <= {r_filt[FILTER_LEN-2:0], r_clk_sync[1]};
      if (w_all_low) begin
        r_clk_filt <= 1'b0;
      end else if (w_all_high) begin
        r_clk_filt <= 1'b1;
      end
    end
  end

  // High for exactly the cycle in which the filtered clock is about to drop.
  assign fall_evt = r_clk_filt & w_all_low;
  assign data_s   = r_data_sync[1];

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deframes 11-bit device-to-host frames and holds the
// last good scan code with a level data-available flag until acknowledged.
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clear_kbd,
  output logic [7:0] kbd_databus,
  output logic       kbd_rda,
  output logic       frame_err,
  output logic       overrun
);
  import ps2_pkg::*;

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  ps2_state_t       r_state, w_state_nxt;
  logic [2:0]       r_bitcnt, w_bitcnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_par_ok, w_par_ok_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic [7:0]       r_databus;
  logic             r_rda;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_fall_evt;
  logic             w_data_s;
  logic             w_tmo_hit;
  logic             w_frame_ok;
  logic             w_frame_bad;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line_filter (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall_evt (w_fall_evt),
    .data_s   (w_data_s)
  );

  // A sample event always wins over an expiring timeout in the same cycle.
  assign w_tmo_hit = (r_state != IDLE) && !w_fall_evt && (r_tmo == TMO_LAST);

  // Deframing next-state logic and timeout counter update.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_par_ok_nxt = r_par_ok;
    w_frame_ok   = 1'b0;
    w_frame_bad  = 1'b0;
    if (w_fall_evt || (r_state == IDLE)) begin
      w_tmo_nxt = '0;
    end else begin
      w_tmo_nxt = r_tmo + TMO_W'(1);
    end
    if (w_tmo_hit) begin
      w_state_nxt = IDLE;
      w_frame_bad = 1'b1;
      w_tmo_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fall_evt && !w_data_s) begin
            w_state_nxt  = DATA;
            w_bitcnt_nxt = 3'd0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        DATA: begin
          if (w_fall_evt) begin
            w_shift_nxt  = {w_data_s, r_shift[7:1]};
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            if (r_bitcnt == LAST_BIT) begin
              w_state_nxt = PARITY;
            end else begin
              w_state_nxt = DATA;
            end
          end else begin
            w_state_nxt = DATA;
          end
        end
        PARITY: begin
          if (w_fall_evt) begin
            w_par_ok_nxt = odd_parity_ok(r_shift, w_data_s);
            w_state_nxt  = STOP;
          end else begin
            w_state_nxt = PARITY;
          end
        end
        STOP: begin
          if (w_fall_evt) begin
            w_state_nxt = IDLE;
            if (w_data_s && r_par_ok) begin
              w_frame_ok = 1'b1;
            end else begin
              w_frame_bad = 1'b1;
            end
          end else begin
            w_state_nxt = STOP;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Deframer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
      r_par_ok <= 1'b0;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_par_ok <= w_par_ok_nxt;
      r_tmo    <= w_tmo_nxt;
    end
  end

  // Output holding registers; an acknowledge in the completing cycle frees the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_databus   <= 8'h00;
      r_rda       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      if (w_frame_ok && (!r_rda || clear_kbd)) begin
        r_databus <= r_shift;
        r_rda     <= 1'b1;
        if (clear_kbd) begin
          r_overrun <= 1'b0;
        end
      end else if (w_frame_ok) begin
        r_overrun <= 1'b1;
      end else if (clear_kbd) begin
        r_rda     <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign kbd_databus = r_databus;
  assign kbd_rda     = r_rda;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx with a byte scoreboard; the PS/2
// bit clock is shortened so the whole run stays small.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
  import ps2_pkg::*;

  localparam int F    = 8;
  localparam int TMO  = 20000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       clear_kbd = 1'b0;
  logic [7:0] kbd_databus;
  logic       kbd_rda;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int last_fall_cyc = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int loads = 0;
  int e0, l0, elapsed;
  logic [7:0] exp_q[$];
  logic       rda_prev = 1'b0;
  logic       err_prev = 1'b0;
  logic [7:0] db_prev = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_kbd_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .clear_kbd   (clear_kbd),
    .kbd_databus (kbd_databus),
    .kbd_rda     (kbd_rda),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_kbd = 1'b1;
    tick(1);
    clear_kbd = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit clr_at_stop);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = fr[i];
      tick(HALF);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (i == 10) stop_cyc = cyc;
      if (i == 10 && clr_at_stop) begin
        tick(F + 2);
        clear_kbd = 1'b1;
        tick(1);
        clear_kbd = 1'b0;
        tick(HALF - F - 3);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    logic [8:0] fr;
    fr = {b, 1'b0};
    for (int i = 0; i <= n; i++) begin
      ps2_data = fr[i];
      tick(HALF);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every newly presented byte and tracks error pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
        if (err_prev) chk("frame_err_width", 32'(err_prev), 32'd0);
      end
      if (kbd_rda && (!rda_prev || kbd_databus != db_prev)) begin
        loads <= loads + 1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_byte: observed=%0h expected=none", kbd_databus);
        end else begin
          chk("sb_byte", 32'(kbd_databus), 32'(exp_q.pop_front()));
          chk("rda_latency", 32'(cyc - stop_cyc), 32'(F + 3));
        end
      end
    end
    rda_prev <= kbd_rda;
    db_prev  <= kbd_databus;
    err_prev <= frame_err;
  end

  initial begin
    tick(3);
    #1;
    chk("rst_databus", 32'(kbd_databus), 32'h00);
    chk("rst_rda", 32'(kbd_rda), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(HALF);

    // Clean 0x1D frame.
    exp_q.push_back(8'h1D);
    send_frame(8'h1D, 1'b0, 1'b0);
    chk("1d_databus", 32'(kbd_databus), 32'h1D);
    chk("1d_rda", 32'(kbd_rda), 32'd1);
    chk("1d_no_err", 32'(err_cnt), 32'd0);
    pulse_clear();
    chk("clear_rda", 32'(kbd_rda), 32'd0);

    // Bad parity.
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("par_err_cnt", 32'(err_cnt), 32'd1);
    chk("par_rda", 32'(kbd_rda), 32'd0);
    chk("par_databus", 32'(kbd_databus), 32'h1D);

    // Overrun: second byte discarded.
    exp_q.push_back(SC_BREAK);
    send_frame(SC_BREAK, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    chk("ovr_databus", 32'(kbd_databus), 32'hF0);
    chk("ovr_rda", 32'(kbd_rda), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    pulse_clear();
    chk("ovr_clr_rda", 32'(kbd_rda), 32'd0);
    chk("ovr_clr_flag", 32'(overrun), 32'd0);

    // Acknowledge in the same cycle a new byte completes.
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b0, 1'b0);
    exp_q.push_back(8'h23);
    send_frame(8'h23, 1'b0, 1'b1);
    chk("simul_databus", 32'(kbd_databus), 32'h23);
    chk("simul_rda", 32'(kbd_rda), 32'd1);
    chk("simul_overrun", 32'(overrun), 32'd0);
    pulse_clear();

    // Mid-frame timeout.
    e0 = err_cnt;
    send_partial(8'h55, 3);
    for (int i = 0; i < TMO + 5000 && err_cnt == e0; i++) @(negedge clk);
    elapsed = err_cyc - last_fall_cyc;
    tick(50);
    chk("tmo_err_once", 32'(err_cnt), 32'(e0 + 1));
    chk("tmo_latency_window", 32'((elapsed >= TMO + F) && (elapsed <= TMO + F + 6)), 32'd1);
    chk("tmo_rda", 32'(kbd_rda), 32'd0);
    chk("tmo_databus", 32'(kbd_databus), 32'h23);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b0, 1'b0);
    chk("post_tmo_databus", 32'(kbd_databus), 32'h12);
    chk("post_tmo_rda", 32'(kbd_rda), 32'd1);

    // Short clock glitches and an idle pulse with data high do nothing.
    e0 = err_cnt;
    l0 = loads;
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      tick(20);
    end
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF);
    chk("glitch_err", 32'(err_cnt), 32'(e0));
    chk("glitch_loads", 32'(loads), 32'(l0));
    chk("glitch_databus", 32'(kbd_databus), 32'h12);
    pulse_clear();

    // Asynchronous reset in the middle of a frame.
    exp_q.push_back(8'h1D);
    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(SC_EXTEND, 1'b0, 1'b0);
    chk("pre_rst_overrun", 32'(overrun), 32'd1);
    send_partial(8'hAA, 4);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_databus", 32'(kbd_databus), 32'h00);
    chk("mid_rst_rda", 32'(kbd_rda), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    tick(HALF);
    e0 = err_cnt;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b0, 1'b0);
    chk("post_rst_databus", 32'(kbd_databus), 32'h12);
    chk("post_rst_rda", 32'(kbd_rda), 32'd1);
    chk("post_rst_err", 32'(err_cnt), 32'(e0));

    tick(10);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
